// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the packet-granular AXI-Stream arbiter.
// The AXIS_ARB_WATCHDOG_EN macro adds the stall-timeout default.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_USER_WIDTH = 12;
`ifdef AXIS_ARB_WATCHDOG_EN
    localparam int DEF_TIMEOUT_CYCLES = 1024;
`endif

    function automatic int gnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping from N-1 back to 0.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = gnt_w(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    always_comb begin
        int c;
        c        = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = int'(i_ptr) + k;
            if (c >= N) c = c - N;
            if (!o_valid && i_req[c]) begin
                o_valid     = 1'b1;
                o_idx       = W'(c);
                o_onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC byte streams into one registered AXIS master.
// Define AXIS_ARB_WATCHDOG_EN to abort mid-packet stalls after TIMEOUT_CYCLES.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int USER_WIDTH = DEF_USER_WIDTH
`ifdef AXIS_ARB_WATCHDOG_EN
    , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_data,
    input  logic [NUM_SRC*USER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_SRC-1:0]             s_axis_last,
    input  logic [NUM_SRC-1:0]             s_axis_valid,
    output logic [NUM_SRC-1:0]             s_axis_ready,
    output logic [DATA_WIDTH-1:0]          m_axis_data,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic                           m_axis_last,
    output logic                           m_axis_valid,
    input  logic                           m_axis_ready,
    output logic [gnt_w(NUM_SRC)-1:0]      grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int GNT_W = gnt_w(NUM_SRC);
    localparam logic [GNT_W-1:0] LAST_IDX = GNT_W'(NUM_SRC - 1);

    arb_state_t             r_state, w_state_next;
    logic [GNT_W-1:0]       r_grant, r_ptr, w_pick_idx, w_grant_inc;
    logic [NUM_SRC-1:0]     r_gnt_onehot, w_pick_onehot, w_drop_mask;
    logic                   w_pick_valid, w_out_free, w_hs, w_pkt_end, w_timeout;
    logic                   w_sel_valid, w_sel_last;
    logic [DATA_WIDTH-1:0]  w_data_arr [NUM_SRC];
    logic [USER_WIDTH-1:0]  w_user_arr [NUM_SRC];
    logic [DATA_WIDTH-1:0]  r_m_data;
    logic [USER_WIDTH-1:0]  r_m_user;
    logic                   r_m_last, r_m_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_data_arr[gi] = s_axis_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_user_arr[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
        end
    endgenerate

    assign w_sel_valid = s_axis_valid[r_grant];
    assign w_sel_last  = s_axis_last[r_grant];
    assign w_out_free  = ~r_m_valid | m_axis_ready;
    assign w_hs        = (r_state == ST_LOCK) & w_sel_valid & w_out_free & ~w_timeout;
    assign w_pkt_end   = w_hs & w_sel_last;
    assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    rr_pick #(.N(NUM_SRC), .W(GNT_W)) u_pick (
        .i_req    (s_axis_valid & ~w_drop_mask),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

`ifdef AXIS_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0]    r_wd_cnt;
    logic [NUM_SRC-1:0] r_drop;
    logic               r_timeout_err;

    // The abort byte needs a free output slot, so expiry waits for it.
    assign w_timeout   = (r_state == ST_LOCK) & (r_wd_cnt == WD_LIMIT) & w_out_free;
    assign w_drop_mask = r_drop;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state != ST_LOCK || w_hs || w_timeout)
                r_wd_cnt <= '0;
            else if (!w_sel_valid && r_wd_cnt != WD_LIMIT)
                r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_drop
            always_ff @(posedge clk) begin
                if (rst)
                    r_drop[gi] <= 1'b0;
                else if (w_timeout && r_gnt_onehot[gi])
                    r_drop[gi] <= 1'b1;
                else if (r_drop[gi] && s_axis_valid[gi] && s_axis_last[gi])
                    r_drop[gi] <= 1'b0;
            end
        end
    endgenerate
`else
    assign w_timeout   = 1'b0;
    assign w_drop_mask = '0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_valid) w_state_next = ST_LOCK;
            ST_LOCK: if (w_pkt_end || w_timeout) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state == ST_LOCK);
        s_axis_ready = w_drop_mask;
        if (r_state == ST_LOCK && w_out_free && !w_timeout)
            s_axis_ready = s_axis_ready | r_gnt_onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_gnt_onehot <= '0;
            r_ptr        <= '0;
        end else begin
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_grant      <= w_pick_idx;
                r_gnt_onehot <= w_pick_onehot;
            end
            if (w_pkt_end || w_timeout)
                r_ptr <= w_grant_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data  <= '0;
            r_m_user  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_hs) begin
            r_m_data  <= w_data_arr[r_grant];
            r_m_user  <= w_user_arr[r_grant];
            r_m_last  <= w_sel_last;
            r_m_valid <= 1'b1;
        end else if (w_timeout) begin
            r_m_data  <= '0;
            r_m_user  <= '0;
            r_m_last  <= 1'b1;
            r_m_valid <= 1'b1;
        end else if (m_axis_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_axis_data  = r_m_data;
    assign m_axis_tuser = r_m_user;
    assign m_axis_last  = r_m_last;
    assign m_axis_valid = r_m_valid;
    assign grant_id     = r_grant;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed scoreboard bench for axis_pkt_arbiter (default build, watchdog disabled).
module tb_axis_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int UW = 12;
    localparam int GW = 2;

    typedef logic [DW+UW:0] beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   s_data;
    logic [N*UW-1:0]   s_user;
    logic [N-1:0]      s_last, s_valid, s_ready;
    logic [DW-1:0]     m_data;
    logic [UW-1:0]     m_user;
    logic              m_last, m_valid, m_ready;
    logic [GW-1:0]     grant_id;
    logic              busy, timeout_err;

    beat_t src_q [N][$];
    beat_t sb_q [$];
    int    total = 0;
    int    bad   = 0;
    bit    mrdy_toggle = 1'b0;
    logic  prev_v, prev_r;
    beat_t prev_b;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data(s_data), .s_axis_tuser(s_user), .s_axis_last(s_last),
        .s_axis_valid(s_valid), .s_axis_ready(s_ready),
        .m_axis_data(m_data), .m_axis_tuser(m_user), .m_axis_last(m_last),
        .m_axis_valid(m_valid), .m_axis_ready(m_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_valid[i] = 1'b1;
                {s_last[i], s_user[i*UW +: UW], s_data[i*DW +: DW]} = src_q[i][0];
            end else begin
                s_valid[i] = 1'b0;
                {s_last[i], s_user[i*UW +: UW], s_data[i*DW +: DW]} = '0;
            end
        end
    endtask

    // Packets must be added in the order the arbiter is expected to forward them.
    task automatic add_pkt(input int src, input int len, input int seed);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b = {(k == len - 1), UW'(src * 16 + k + seed), DW'(seed + k * 13 + src * 3)};
            src_q[src].push_back(b);
            sb_q.push_back(b);
        end
    endtask

    task automatic step();
        logic [N-1:0] hs;
        #1;
        hs = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i]) void'(src_q[i].pop_front());
        m_ready = mrdy_toggle ? ~m_ready : 1'b1;
        present();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0) return 1'b0;
        return (sb_q.size() == 0);
    endfunction

    task automatic drain(input string tag, input int max);
        int n = 0;
        while (n < max && !(all_empty() && !m_valid)) begin
            step();
            n++;
        end
        chk(tag, 32'(n < max), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
        present();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every accepted beat, checks hold while stalled.
    always @(negedge clk) begin
        beat_t b, exp_b;
        b = {m_last, m_user, m_data};
        if (rst) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_beat", 32'(b), 32'(prev_b));
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'(b), 32'hFFFF_FFFF);
                end else begin
                    exp_b = sb_q.pop_front();
                    chk("beat", 32'(b), 32'(exp_b));
                    $display("beat data=%02h user=%03h last=%0b grant=%0d", m_data, m_user, m_last, grant_id);
                end
            end
            prev_v <= m_valid;
            prev_r <= m_ready;
            prev_b <= b;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        s_valid = '0; s_last = '0; s_data = '0; s_user = '0;
        m_ready = 1'b1;
        do_reset();

        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'({m_last, m_user, m_data}), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);

        // 1: src1 five-byte packet, one arbitration cycle, full throughput
        add_pkt(1, 5, 8'h20);
        present();
        #1;
        chk("t1_arb_ready", 32'(s_ready), 32'd0);
        chk("t1_arb_busy", 32'(busy), 32'd0);
        step();
        chk("t1_lock_busy", 32'(busy), 32'd1);
        chk("t1_lock_grant", 32'(grant_id), 32'd1);
        chk("t1_lock_ready", 32'(s_ready), 32'b0010);
        repeat (5) step();
        @(negedge clk);
        #1;
        chk("t1_throughput", 32'(sb_q.size()), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        drain("t1_drain", 20);
        chk("t1_grant_hold", 32'(grant_id), 32'd1);

        // 2: src0,2,3 together from pointer 0; then 0 and 1 to show pointer wrapped to 0
        do_reset();
        add_pkt(0, 3, 8'h40);
        add_pkt(2, 3, 8'h50);
        add_pkt(3, 3, 8'h60);
        present();
        drain("t2_drain", 60);
        chk("t2_grant", 32'(grant_id), 32'd3);
        add_pkt(0, 2, 8'h70);
        add_pkt(1, 2, 8'h78);
        present();
        drain("t2b_drain", 40);
        chk("t2b_grant", 32'(grant_id), 32'd1);

        // 3: downstream ready toggling mid-packet on src2
        mrdy_toggle = 1'b1;
        add_pkt(2, 6, 8'h90);
        present();
        drain("t3_drain", 60);
        mrdy_toggle = 1'b0;
        m_ready = 1'b1;
        step();

        // 4: src3 single-byte packet, then src0 and src2 from the wrapped pointer
        add_pkt(3, 1, 8'hA0);
        present();
        drain("t4_drain", 20);
        chk("t4_grant", 32'(grant_id), 32'd3);
        add_pkt(0, 2, 8'hB0);
        add_pkt(2, 2, 8'hB8);
        present();
        drain("t4b_drain", 40);
        chk("t4b_grant", 32'(grant_id), 32'd2);

        // 5: reset in the middle of a src2 packet, then re-arbitrate from pointer 0
        add_pkt(2, 6, 8'hC0);
        present();
        repeat (4) step();
        chk("t5_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
        present();
        @(posedge clk);
        #1;
        chk("t5_rst_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'd0);
        chk("t5_rst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        add_pkt(1, 2, 8'hD0);
        add_pkt(3, 2, 8'hD8);
        present();
        drain("t5_drain", 40);
        chk("t5_grant", 32'(grant_id), 32'd3);

        chk("end_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("end_timeout", 32'(timeout_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
